// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: shares the single VRAM port between the BG fetch
// pipeline (char_cycle slots 1, 5, 7 while bg_active) and a small queue of
// CPU reads/writes that issue in the remaining free slots.
// Build option: VRAM_DISP_LOCKOUT_EN -- when defined, no CPU access issues
// while bg_active = 1 (strict active-display behaviour).
module vram_slot_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clock_en,
  input  logic [2:0]        char_cycle,
  input  logic              bg_active,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_full,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] MA,
  output logic [DATA_W-1:0] MD_out,
  output logic              vram_we,
  input  logic [DATA_W-1:0] MD_in
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Request queue storage and control
  logic              fifo_we_r    [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_r  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next_s;
  logic              cpu_full_r;

  // Read return path
  logic              rd_pending_r;
  logic              cpu_rvalid_r;
  logic [DATA_W-1:0] cpu_rdata_r;

  // Slot and grant decode
  logic              bg_slot_s;
  logic              free_slot_s;
  logic              fifo_empty_s;
  logic              grant_s;
  logic              push_s;
  logic              head_we_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_wdata_s;
  logic [ADDR_W-1:0] ma_s;
  logic [DATA_W-1:0] md_out_s;

  assign bg_slot_s = bg_active &&
                     ((char_cycle == 3'd1) || (char_cycle == 3'd5) || (char_cycle == 3'd7));

`ifdef VRAM_DISP_LOCKOUT_EN
  assign free_slot_s = !bg_active;
`else
  assign free_slot_s = !bg_slot_s;
`endif

  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign head_we_s    = fifo_we_r[rd_ptr_r];
  assign head_addr_s  = fifo_addr_r[rd_ptr_r];
  assign head_wdata_s = fifo_wdata_r[rd_ptr_r];

  // A write strobe only ever follows a grant, and grant excludes BG slots.
  assign grant_s = free_slot_s && !fifo_empty_s && clock_en;
  // A pop in the same clock never makes room for a push while full.
  assign push_s  = cpu_req && !cpu_full_r;

  // Address/data mux: BG fetch has priority, then the queue head, else idle zero.
  always_comb begin
    ma_s     = {ADDR_W{1'b0}};
    md_out_s = {DATA_W{1'b0}};
    if (bg_slot_s) begin
      ma_s = bg_addr;
    end else if (!fifo_empty_s) begin
      ma_s     = head_addr_s;
      md_out_s = head_wdata_s;
    end else begin
      ma_s     = {ADDR_W{1'b0}};
      md_out_s = {DATA_W{1'b0}};
    end
  end

  // Next occupancy from the push/pop pair; simultaneous push and pop cancel.
  always_comb begin
    count_next_s = count_r;
    if (push_s && !grant_s) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (!push_s && grant_s) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Queue payload capture; contents are don't-care until pushed.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_we_r[wr_ptr_r]    <= cpu_we;
      fifo_addr_r[wr_ptr_r]  <= cpu_addr;
      fifo_wdata_r[wr_ptr_r] <= cpu_wdata;
    end
  end

  // Queue pointers, occupancy and registered full flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      cpu_full_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (grant_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_next_s;
      cpu_full_r <= (count_next_s == CNT_W'(FIFO_DEPTH));
    end
  end

  // Read return: MD_in for a granted read is captured on the next enabled tick,
  // even if that tick is a BG slot (MD_in still belongs to the CPU address).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pending_r <= 1'b0;
      cpu_rvalid_r <= 1'b0;
      cpu_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      cpu_rvalid_r <= 1'b0;
      if (clock_en) begin
        rd_pending_r <= grant_s && !head_we_s;
        if (rd_pending_r) begin
          cpu_rvalid_r <= 1'b1;
          cpu_rdata_r  <= MD_in;
        end
      end
    end
  end

  assign MA         = ma_s;
  assign MD_out     = md_out_s;
  assign vram_we    = grant_s && head_we_s;
  assign cpu_full   = cpu_full_r;
  assign cpu_rvalid = cpu_rvalid_r;
  assign cpu_rdata  = cpu_rdata_r;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter with a one-tick-latency VRAM model.
module tb_vram_slot_arbiter;

  logic        clock;
  logic        reset;
  logic        clock_en;
  logic [2:0]  char_cycle;
  logic        bg_active;
  logic [15:0] bg_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_full;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic [15:0] MA;
  logic [15:0] MD_out;
  logic        vram_we;
  logic [15:0] MD_in;

  logic [15:0] vram_mem [0:65535];

  int checks_total;
  int checks_passed;

  vram_slot_arbiter #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .clock_en(clock_en), .char_cycle(char_cycle),
    .bg_active(bg_active), .bg_addr(bg_addr), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_full(cpu_full),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .MA(MA), .MD_out(MD_out),
    .vram_we(vram_we), .MD_in(MD_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // VRAM model: write on strobe, read data appears one enabled tick later.
  always @(posedge clock) begin
    if (clock_en) begin
      if (vram_we) vram_mem[MA] <= MD_out;
      MD_in <= vram_mem[MA];
    end
  end

  task automatic push(input logic we, input logic [15:0] addr, input logic [15:0] data);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    @(posedge clock); #1;
    cpu_req   = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks_total++;
    if ({cpu_full, cpu_rvalid, cpu_rdata, MD_out, vram_we, MA} !== 51'd0)
      $display("FAIL reset_outputs: got full=%b rvalid=%b rdata=%h md=%h we=%b ma=%h, expected all zero",
               cpu_full, cpu_rvalid, cpu_rdata, MD_out, vram_we, MA);
    else checks_passed++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_write;
    clock_en = 1'b1;
    push(1'b1, 16'h0120, 16'hBEEF);
    checks_total++;
    if ({MA, MD_out, vram_we} !== {16'h0120, 16'hBEEF, 1'b1})
      $display("FAIL write_issue: got ma=%h md=%h we=%b, expected 0120 beef 1", MA, MD_out, vram_we);
    else checks_passed++;
    @(posedge clock); #1;
    checks_total++;
    if ({MA, MD_out, vram_we} !== {16'h0000, 16'h0000, 1'b0})
      $display("FAIL write_done: got ma=%h md=%h we=%b, expected 0000 0000 0", MA, MD_out, vram_we);
    else checks_passed++;
  endtask

  task automatic test_write_then_read;
    push(1'b1, 16'h0040, 16'h1234);
    push(1'b0, 16'h0040, 16'h0000);
    checks_total++;
    if ({MA, vram_we} !== {16'h0040, 1'b0})
      $display("FAIL read_grant: got ma=%h we=%b, expected 0040 0", MA, vram_we);
    else checks_passed++;
    @(posedge clock); #1;
    checks_total++;
    if (cpu_rvalid !== 1'b0)
      $display("FAIL read_early: got rvalid=%b, expected 0", cpu_rvalid);
    else checks_passed++;
    @(posedge clock); #1;
    checks_total++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h1234})
      $display("FAIL read_return: got rvalid=%b rdata=%h, expected 1 1234", cpu_rvalid, cpu_rdata);
    else checks_passed++;
    @(posedge clock); #1;
    checks_total++;
    if (cpu_rvalid !== 1'b0)
      $display("FAIL read_pulse_width: got rvalid=%b, expected 0", cpu_rvalid);
    else checks_passed++;
  endtask

  task automatic test_bg_slots;
    logic [15:0] exp_ma [8];
    logic        exp_v  [8];
    logic [15:0] exp_d  [8];
    exp_ma = '{16'h0010, 16'h0200, 16'h0011, 16'h0012, 16'h0000, 16'h0200, 16'h0000, 16'h0200};
    exp_v  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_d  = '{16'h0000, 16'hA0A0, 16'h0000, 16'hB1B1, 16'hC2C2, 16'h0000, 16'h0000, 16'h0000};
    push(1'b1, 16'h0010, 16'hA0A0);
    push(1'b1, 16'h0011, 16'hB1B1);
    push(1'b1, 16'h0012, 16'hC2C2);
    repeat (2) @(posedge clock);
    #1;
    clock_en = 1'b0;
    push(1'b0, 16'h0010, 16'h0000);
    push(1'b0, 16'h0011, 16'h0000);
    push(1'b0, 16'h0012, 16'h0000);
    bg_active = 1'b1;
    bg_addr   = 16'h0200;
    clock_en  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      char_cycle = 3'(c);
      #1;
      checks_total++;
      if ({MA, vram_we} !== {exp_ma[c], 1'b0})
        $display("FAIL bg_ma_slot%0d: got ma=%h we=%b, expected %h 0", c, MA, vram_we, exp_ma[c]);
      else checks_passed++;
      @(posedge clock); #1;
      checks_total++;
      if (cpu_rvalid !== exp_v[c] || (exp_v[c] && cpu_rdata !== exp_d[c]))
        $display("FAIL bg_ret_slot%0d: got rvalid=%b rdata=%h, expected %b %h",
                 c, cpu_rvalid, cpu_rdata, exp_v[c], exp_d[c]);
      else checks_passed++;
    end
    bg_active  = 1'b0;
    char_cycle = 3'd0;
  endtask

  task automatic test_full;
    clock_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 16'h0300 + 16'(i), 16'h5500 + 16'(i));
      checks_total++;
      if (cpu_full !== (i == 3))
        $display("FAIL full_after_push%0d: got full=%b, expected %b", i, cpu_full, (i == 3));
      else checks_passed++;
    end
    push(1'b1, 16'h03FF, 16'hDEAD);
    checks_total++;
    if (cpu_full !== 1'b1)
      $display("FAIL full_hold: got full=%b, expected 1", cpu_full);
    else checks_passed++;
    clock_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks_total++;
      if ({vram_we, MA, MD_out} !== {1'b1, 16'h0300 + 16'(i), 16'h5500 + 16'(i)})
        $display("FAIL drain_issue%0d: got we=%b ma=%h md=%h, expected 1 %h %h",
                 i, vram_we, MA, MD_out, 16'h0300 + 16'(i), 16'h5500 + 16'(i));
      else checks_passed++;
      @(posedge clock); #1;
      if (i == 0) begin
        checks_total++;
        if (cpu_full !== 1'b0)
          $display("FAIL full_drop: got full=%b, expected 0", cpu_full);
        else checks_passed++;
      end
    end
    #1;
    checks_total++;
    if ({vram_we, MA} !== {1'b0, 16'h0000})
      $display("FAIL drain_empty: got we=%b ma=%h, expected 0 0000 (5th request dropped)", vram_we, MA);
    else checks_passed++;
  endtask

  task automatic test_reset_inflight;
    push(1'b0, 16'h0010, 16'h0000);
    push(1'b0, 16'h0011, 16'h0000);
    reset = 1'b1;
    #1;
    checks_total++;
    if ({cpu_rvalid, cpu_full, vram_we, MA} !== {1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_flush: got rvalid=%b full=%b we=%b ma=%h, expected 0 0 0 0000",
               cpu_rvalid, cpu_full, vram_we, MA);
    else checks_passed++;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks_total++;
      if ({cpu_rvalid, MA} !== {1'b0, 16'h0000})
        $display("FAIL reset_no_return%0d: got rvalid=%b ma=%h, expected 0 0000", i, cpu_rvalid, MA);
      else checks_passed++;
    end
  endtask

`ifdef VRAM_DISP_LOCKOUT_EN
  task automatic test_lockout;
    clock_en   = 1'b1;
    bg_active  = 1'b1;
    bg_addr    = 16'h0200;
    char_cycle = 3'd0;
    push(1'b1, 16'h0500, 16'h7777);
    for (int i = 0; i < 16; i++) begin
      char_cycle = 3'(i);
      #1;
      checks_total++;
      if (vram_we !== 1'b0)
        $display("FAIL lockout_tick%0d: got we=%b, expected 0", i, vram_we);
      else checks_passed++;
      @(posedge clock); #1;
    end
    bg_active = 1'b0;
    #1;
    checks_total++;
    if ({vram_we, MA, MD_out} !== {1'b1, 16'h0500, 16'h7777})
      $display("FAIL lockout_release: got we=%b ma=%h md=%h, expected 1 0500 7777", vram_we, MA, MD_out);
    else checks_passed++;
    @(posedge clock); #1;
  endtask
`endif

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset      = 1'b1;
    clock_en   = 1'b0;
    char_cycle = 3'd0;
    bg_active  = 1'b0;
    bg_addr    = 16'h0000;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = 16'h0000;
    cpu_wdata  = 16'h0000;
    test_reset();
    test_single_write();
    test_write_then_read();
`ifdef VRAM_DISP_LOCKOUT_EN
    test_lockout();
`else
    test_bg_slots();
`endif
    test_full();
    test_reset_inflight();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/vram_slot_arbiter.md
Name: vram_slot_arbiter

Overview:
- Sequences all VRAM accesses for the HuC6270 VDC model.
- Shares the single VRAM address/data port between two requesters:
  - the background fetch pipeline, which owns char_cycle slots 1, 5 and 7 during BG fetch;
  - CPU-side VRAM reads and writes, which are queued in a small request FIFO and issued in free slots.
- Drives MA, MD_out and the VRAM write strobe, and returns CPU read data in order.

Parameters:
- ADDR_W, 16, VRAM word-address width.
- DATA_W, 16, VRAM data width.
- FIFO_DEPTH, 4, CPU request queue depth; power of two, at least 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clock_en  in  1  dot-clock enable; all VRAM issue and pipeline advance happen only on ticks where this is 1.
- char_cycle  in  3  current position within the 8-cycle character cycle.
- bg_active  in  1  BG fetch window active (same condition as do_BGfetch).
- bg_addr  in  ADDR_W  BG fetch address, valid in BG slots.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU access address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_full  out  1  request FIFO full (feeds BUSY_n).
- cpu_rvalid  out  1  one-clock pulse: cpu_rdata is valid.
- cpu_rdata  out  DATA_W  CPU read data.
- MA  out  ADDR_W  VRAM address.
- MD_out  out  DATA_W  VRAM write data.
- vram_we  out  1  VRAM write strobe.
- MD_in  in  DATA_W  VRAM read data, valid one clock_en tick after the address is presented.

Behaviour:
- Reset state: FIFO empty; read-pending flag cleared.
- Reset values of outputs:
  - cpu_full = 0, cpu_rvalid = 0, cpu_rdata = 0, MD_out = 0, vram_we = 0.
  - MA = 0 while the FIFO is empty and bg_active = 0.
- Asserting reset mid-operation discards all queued requests and any in-flight read; no cpu_rvalid is produced for them.
- BG slot definition (combinational): bg_slot = bg_active and char_cycle is one of {1, 5, 7}. A slot is free whenever bg_slot = 0.
- MA priority (combinational):
  - if bg_slot, MA = bg_addr;
  - else if the FIFO is non-empty, MA = head.addr and MD_out = head.wdata;
  - else MA = 0.
- CPU grant: grant = free slot, FIFO non-empty, and clock_en = 1.
- vram_we = grant and head.we. It is combinational and lasts exactly one clock. vram_we is never 1 during a BG slot.
- Pop: the FIFO head is popped on the clock edge at which grant = 1. At most one CPU access is issued per tick.
- Read return:
  - a granted read sets rd_pending for the next tick;
  - on the next clock_en tick, cpu_rdata is registered from MD_in and cpu_rvalid pulses for one clock.
  - Back-to-back reads in consecutive free ticks are legal and return in order.
  - If the following tick is a BG slot, the read is still captured. The capture reads MD_in belonging to the previous address, which makes it conflict-free.
- Push:
  - occurs on any clock where cpu_req = 1 and cpu_full = 0, independent of clock_en;
  - captures {we, addr, wdata}.
  - cpu_req while full is ignored and dropped; the CPU side must honour cpu_full.
- Full and empty flags:
  - cpu_full is registered, equal to count == FIFO_DEPTH.
  - Simultaneous push and pop when not full: count is unchanged and ordering is preserved.
  - A pop in the same cycle does not make room for a push while full.
- Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- Ordering: accesses complete strictly in arrival order. A read issued after a write to the same address returns the new data.

Optional Feature:
- Macro: VRAM_DISP_LOCKOUT_EN.
- Defined: while bg_active = 1, every slot is treated as non-free, so CPU accesses are deferred until bg_active = 0. This matches strict hardware behaviour during active display.
- Undefined: CPU accesses use the free slots (char_cycle 0, 2, 3, 4, 6) during BG fetch.

Test Plan:
- Reset, then a single write with bg_active = 0: cpu_addr = 16'h0120, cpu_wdata = 16'hBEEF, clock_en always 1.
  - Next clock: MA = 16'h0120, MD_out = 16'hBEEF, vram_we = 1 for one clock.
  - FIFO then empty and MA = 0.
- Write 16'h1234 to 16'h0040, then read 16'h0040 with the VRAM model attached: cpu_rvalid pulses with cpu_rdata = 16'h1234 exactly two clock_en ticks after the read is granted.
- bg_active = 1, char_cycle sweeping 0 to 7, bg_addr = 16'h0200, FIFO holding 3 reads:
  - MA = 16'h0200 in slots 1, 5 and 7;
  - the reads issue in slots 0, 2 and 3, and return in order.
- Push 4 requests with clock_en = 0: cpu_full = 1, and a 5th cpu_req is dropped.
  - Enable clock_en: exactly 4 accesses issue and cpu_full drops after the first pop.
- Read granted, then reset asserted before the capture tick: cpu_rvalid stays 0, count = 0, MA = 0.
- With VRAM_DISP_LOCKOUT_EN defined, bg_active = 1 for 16 ticks with a queued write: no vram_we pulse occurs; the write issues on the first tick after bg_active falls.
